// File: rtl/ifns_pkg.sv
// Shared types and helpers for the IFNS link scheduler slice.
package ifns_pkg;

   localparam int DATA_W = 6;
   localparam int CODE_W = 8;

   typedef enum logic {IDLE, GRANT} state_t;

   // Pointer advance after a grant, wrapping at the requester count.
   function automatic logic [7:0] rr_next(input logic [7:0] idx, input logic [7:0] num_req);
      return (idx >= num_req - 8'd1) ? 8'd0 : idx + 8'd1;
   endfunction

endpackage

// File: rtl/encoderIFNS_6di_core.sv
// Fibonacci-numeral 6-bit to 8-bit crosstalk-avoidance encoder core.
// Codeword bit k carries weight FIB[k]; digits are chosen greedily from the top weight down.
module encoderIFNS_6di_core (
   input  logic [5:0] data,
   output logic [7:0] code
);

   localparam logic [5:0] FIB [8] = '{6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34};

   logic [5:0] rem;

   always_comb begin
      code = '0;
      rem  = data;
      for (int k = 7; k >= 0; k--) begin
         if (rem >= FIB[k]) begin
            code[k] = 1'b1;
            rem     = rem - FIB[k];
         end
      end
   end

endmodule

// File: rtl/ifns_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module ifns_rr_arbiter
   import ifns_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;
   logic [SRC_W-1:0]     offset;
   logic [SRC_W:0]       sum;

   assign doubled = {req, req};
   assign rotated = NUM_REQ'(doubled >> ptr);

   // Scan downwards so the lowest rotated position (closest to ptr) is the one kept.
   always_comb begin
      any_req = 1'b0;
      offset  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            any_req = 1'b1;
            offset  = SRC_W'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= (SRC_W + 1)'(NUM_REQ)) begin
         sum = sum - (SRC_W + 1)'(NUM_REQ);
      end
      gnt_idx = sum[SRC_W-1:0];
   end

endmodule

// File: rtl/ifns_link_scheduler.sv
// Round-robin sharing of one IFNS encoder core among bursting requesters,
// with a registered valid/ready codeword output that idles without toggling.
module ifns_link_scheduler
   import ifns_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BEATS = 8,
   parameter int SRC_W     = 2
) (
   input  logic                        clock,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [DATA_W*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [CODE_W-1:0]           codeout,
   output logic                        code_valid,
   output logic [SRC_W-1:0]            code_src,
   output logic                        code_last,
   input  logic                        out_ready,
   output logic                        busy
);

   state_t              state, next_state;
   logic [SRC_W-1:0]    gnt_idx, gnt_next, ptr, ptr_next, arb_idx;
   logic                any_req;
   logic [7:0]          beat_cnt, cnt_next;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_valid, sel_last;
   logic                out_slot_free, accept, grant_end;
   logic [CODE_W-1:0]   enc_code;

   ifns_rr_arbiter #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt_idx (arb_idx),
      .any_req (any_req)
   );

   encoderIFNS_6di_core u_core (
      .data (sel_data),
      .code (enc_code)
   );

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == SRC_W'(i)) begin
            sel_data  = req_data[i*DATA_W +: DATA_W];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
      end
   end

   assign out_slot_free = !code_valid || out_ready;
   assign accept        = (state == GRANT) && sel_valid && out_slot_free;
   assign grant_end     = accept && (sel_last || (beat_cnt == 8'(MAX_BEATS - 1)));
   assign busy          = (state == GRANT);

   always_comb begin
      req_ready = '0;
      if (state == GRANT) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (gnt_idx == SRC_W'(i)) && out_slot_free;
         end
      end
   end

   // A grant ends on the burst's last symbol or when the beat cap is hit;
   // either way the pointer moves past the current winner.
   always_comb begin
      next_state = state;
      gnt_next   = gnt_idx;
      ptr_next   = ptr;
      cnt_next   = beat_cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               gnt_next   = arb_idx;
               cnt_next   = '0;
               next_state = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               if (beat_cnt != 8'hFF) begin
                  cnt_next = beat_cnt + 8'd1;
               end
               if (grant_end) begin
                  ptr_next   = SRC_W'(rr_next(8'(gnt_idx), 8'(NUM_REQ)));
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= IDLE;
         gnt_idx  <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= next_state;
         gnt_idx  <= gnt_next;
         ptr      <= ptr_next;
         beat_cnt <= cnt_next;
      end
   end

   // codeout is only rewritten on accept, so an idle link leaves the bus wires static.
   always_ff @(posedge clock) begin
      if (rst) begin
         codeout    <= '0;
         code_valid <= 1'b0;
         code_src   <= '0;
         code_last  <= 1'b0;
      end else if (accept) begin
         codeout    <= enc_code;
         code_valid <= 1'b1;
         code_src   <= gnt_idx;
         code_last  <= grant_end;
      end else if (out_ready) begin
         code_valid <= 1'b0;
      end
   end

endmodule
